// File: rtl/trivium_ks_packer.sv
// trivium_ks_packer: drives the trivium core reset, skips warm-up bits and packs keystream bit s
// into WORD_W-bit words behind a first-word-fall-through FIFO. Define TRIVIUM_PKR_MSB_FIRST_EN for MSB-first packing.
module trivium_ks_packer #(
  parameter int WORD_W     = 8,
  parameter int WARMUP     = 1152,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              core_rst,
  input  logic              s,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              overflow
);

  localparam int BCW = $clog2(WORD_W);
  localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, WARM, RUN} state_t;

  state_t            state, state_next;
  logic [WORD_W-1:0] shreg, shreg_next;
  logic [BCW-1:0]    bit_cnt;
  logic [WCW-1:0]    warm_cnt;
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr, rd_ptr_next;
  logic [PW:0]       count, count_next;
  logic [WORD_W-1:0] head_next;
  logic              word_done, push, pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = IDLE;
      LOAD: state_next = (WARMUP == 0) ? RUN : WARM;
      WARM: if (warm_cnt == WCW'(WARMUP - 1)) state_next = RUN;
      RUN:  state_next = RUN;
      default: state_next = IDLE;
    endcase
    if (start) state_next = LOAD;
  end

  // The word being completed this edge is the shifted value, so pushes use shreg_next.
  always_comb begin
`ifdef TRIVIUM_PKR_MSB_FIRST_EN
    shreg_next = {shreg[WORD_W-2:0], s};
`else
    shreg_next = {s, shreg[WORD_W-1:1]};
`endif
    word_done   = (state == RUN) && (bit_cnt == BCW'(WORD_W - 1));
    pop         = word_valid && word_ready && !start;
    push        = word_done && !start && ((count != (PW+1)'(FIFO_DEPTH)) || pop);
    rd_ptr_next = rd_ptr + PW'(pop);
    count_next  = count + (PW+1)'(push) - (PW+1)'(pop);
    if (count_next == '0)
      head_next = '0;
    else if (count == (PW+1)'(pop))
      head_next = shreg_next;
    else
      head_next = mem[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shreg_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_rst   <= 1'b1;
      busy       <= 1'b0;
      word       <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      warm_cnt   <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      core_rst <= (state_next == IDLE) || (state_next == LOAD);
      busy     <= (state_next != IDLE);
      if (start) begin
        word       <= '0;
        word_valid <= 1'b0;
        overflow   <= 1'b0;
        shreg      <= '0;
        bit_cnt    <= '0;
        warm_cnt   <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        count      <= '0;
      end else begin
        if (state == WARM) warm_cnt <= warm_cnt + WCW'(1);
        if (state == RUN) begin
          shreg   <= shreg_next;
          bit_cnt <= word_done ? '0 : bit_cnt + BCW'(1);
        end
        // A finished word with no room (and no simultaneous pop) is lost.
        if (word_done && !push) overflow <= 1'b1;
        if (push) wr_ptr <= wr_ptr + PW'(1);
        rd_ptr     <= rd_ptr_next;
        count      <= count_next;
        word       <= head_next;
        word_valid <= (count_next != '0);
      end
    end
  end

endmodule

// File: tb/tb_trivium_ks_packer.sv
// Directed bench for trivium_ks_packer: three instances (WARMUP=0, WARMUP=16, and one fed by
// a behavioural trivium core with key=iv=0).
module tb_trivium_ks_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start0 = 1'b0, s0 = 1'b0, ready0 = 1'b0;
  logic       core_rst0, valid0, busy0, ovf0;
  logic [7:0] word0;

  logic       start16 = 1'b0, s16 = 1'b0, ready16 = 1'b1;
  logic       core_rst16, valid16, busy16, ovf16;
  logic [7:0] word16;

  logic       startt = 1'b0, readyt = 1'b1;
  logic       core_rstt, validt, busyt, ovft, st;
  logic [7:0] wordt;

  int n_checks = 0;
  int n_fails  = 0;

  localparam logic [288:1] TINIT = {3'b111, 285'b0};
  logic [288:1] tst;

  always #5 clk = ~clk;

  trivium_ks_packer #(.WORD_W(8), .WARMUP(0), .FIFO_DEPTH(4)) d0 (
    .clk(clk), .rst(rst), .start(start0), .core_rst(core_rst0), .s(s0),
    .word(word0), .word_valid(valid0), .word_ready(ready0), .busy(busy0), .overflow(ovf0));

  trivium_ks_packer #(.WORD_W(8), .WARMUP(16), .FIFO_DEPTH(4)) d16 (
    .clk(clk), .rst(rst), .start(start16), .core_rst(core_rst16), .s(s16),
    .word(word16), .word_valid(valid16), .word_ready(ready16), .busy(busy16), .overflow(ovf16));

  trivium_ks_packer #(.WORD_W(8), .WARMUP(0), .FIFO_DEPTH(4)) dt (
    .clk(clk), .rst(rst), .start(startt), .core_rst(core_rstt), .s(st),
    .word(wordt), .word_valid(validt), .word_ready(readyt), .busy(busyt), .overflow(ovft));

  function automatic logic [288:1] triv_step(input logic [288:1] x);
    logic t1, t2, t3;
    logic [288:1] y;
    t1 = x[66] ^ x[93] ^ (x[91] & x[92]) ^ x[171];
    t2 = x[162] ^ x[177] ^ (x[175] & x[176]) ^ x[264];
    t3 = x[243] ^ x[288] ^ (x[286] & x[287]) ^ x[69];
    y = x;
    y[93:1]    = {x[92:1], t3};
    y[177:94]  = {x[176:94], t1};
    y[288:178] = {x[287:178], t2};
    return y;
  endfunction

  function automatic logic triv_z(input logic [288:1] x);
    return x[66] ^ x[93] ^ x[162] ^ x[177] ^ x[243] ^ x[288];
  endfunction

  // Behavioural trivium core: loads on core_rst, otherwise steps every clock.
  always @(posedge clk) begin
    if (core_rstt) tst <= TINIT;
    else           tst <= triv_step(tst);
  end
  assign st = triv_z(tst);

  // Stream bit i of b becomes word bit i (LSB-first) or 7-i (MSB-first).
  function automatic logic [7:0] pack8(input logic [7:0] b);
    logic [7:0] r;
`ifdef TRIVIUM_PKR_MSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[7-i] = b[i];
`else
    r = b;
`endif
    return r;
  endfunction

  task automatic start_d0();
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic drive_word0(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      s0 = b[i];
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_checks++;
    if ({core_rst0, busy0, valid0, ovf0, word0} !== {4'b1000, 8'h00}) begin
      n_fails++;
      $display("[TB] FAIL reset_d0: got core_rst/busy/valid/ovf/word=%b%b%b%b/%h, want 1000/00",
               core_rst0, busy0, valid0, ovf0, word0);
    end
    n_checks++;
    if ({core_rst16, busy16, valid16} !== 3'b100) begin
      n_fails++;
      $display("[TB] FAIL reset_d16: got core_rst/busy/valid=%b%b%b, want 100", core_rst16, busy16, valid16);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_pack();
    logic [7:0] b;
    b = 8'b0000_1101;
    ready0 = 1'b1;
    start_d0();
    for (int i = 0; i < 7; i++) begin
      s0 = b[i];
      @(negedge clk);
    end
    n_checks++;
    if (valid0 !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL basic_early_valid: got %b, want 0", valid0);
    end
    s0 = b[7];
    @(negedge clk);
    n_checks++;
    if (valid0 !== 1'b1 || word0 !== pack8(8'h0D)) begin
      n_fails++;
      $display("[TB] FAIL basic_word: got valid=%b word=%h, want valid=1 word=%h", valid0, word0, pack8(8'h0D));
    end
    s0 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (valid0 !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL basic_popped: got valid=%b, want 0", valid0);
    end
  endtask

  task automatic test_warmup();
    n_checks++;
    if (core_rst16 !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL warm_idle_core_rst: got %b, want 1", core_rst16);
    end
    start16 = 1'b1;
    s16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    n_checks++;
    if (core_rst16 !== 1'b1 || busy16 !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL warm_load: got core_rst=%b busy=%b, want 1 1", core_rst16, busy16);
    end
    @(negedge clk);
    n_checks++;
    if (core_rst16 !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL warm_core_rst_low: got %b, want 0", core_rst16);
    end
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      s16 = (i < 4);
      @(negedge clk);
    end
    n_checks++;
    if (valid16 !== 1'b1 || word16 !== pack8(8'h0F) || core_rst16 !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL warm_first_word: got valid=%b word=%h core_rst=%b, want 1 %h 0",
               valid16, word16, core_rst16, pack8(8'h0F));
    end
  endtask

  task automatic test_overflow();
    logic [7:0] w [5];
    w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    ready0 = 1'b0;
    start_d0();
    for (int k = 0; k < 4; k++) drive_word0(w[k]);
    n_checks++;
    if (valid0 !== 1'b1 || word0 !== pack8(w[0]) || ovf0 !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL ovf_full: got valid=%b word=%h ovf=%b, want 1 %h 0", valid0, word0, ovf0, pack8(w[0]));
    end
    drive_word0(w[4]);
    n_checks++;
    if (ovf0 !== 1'b1 || word0 !== pack8(w[0])) begin
      n_fails++;
      $display("[TB] FAIL ovf_drop: got ovf=%b word=%h, want 1 %h", ovf0, word0, pack8(w[0]));
    end
    ready0 = 1'b1;
    s0 = 1'b0;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (valid0 !== 1'b1 || word0 !== pack8(w[k])) begin
        n_fails++;
        $display("[TB] FAIL ovf_drain%0d: got valid=%b word=%h, want 1 %h", k, valid0, word0, pack8(w[k]));
      end
    end
    @(negedge clk);
    n_checks++;
    if (valid0 !== 1'b0 || ovf0 !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL ovf_empty: got valid=%b ovf=%b, want 0 1", valid0, ovf0);
    end
    ready0 = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] w [5];
    w = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    ready0 = 1'b0;
    start_d0();
    for (int k = 0; k < 4; k++) drive_word0(w[k]);
    for (int i = 0; i < 7; i++) begin
      s0 = w[4][i];
      @(negedge clk);
    end
    s0 = w[4][7];
    ready0 = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ovf0 !== 1'b0 || valid0 !== 1'b1 || word0 !== pack8(w[1])) begin
      n_fails++;
      $display("[TB] FAIL fullpp_head: got ovf=%b valid=%b word=%h, want 0 1 %h", ovf0, valid0, word0, pack8(w[1]));
    end
    s0 = 1'b0;
    for (int k = 2; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (valid0 !== 1'b1 || word0 !== pack8(w[k])) begin
        n_fails++;
        $display("[TB] FAIL fullpp_drain%0d: got valid=%b word=%h, want 1 %h", k, valid0, word0, pack8(w[k]));
      end
    end
    @(negedge clk);
    n_checks++;
    if (valid0 !== 1'b0 || ovf0 !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL fullpp_empty: got valid=%b ovf=%b, want 0 0", valid0, ovf0);
    end
    ready0 = 1'b0;
  endtask

  task automatic test_restart();
    logic [7:0] b;
    ready0 = 1'b0;
    start_d0();
    for (int k = 1; k < 6; k++) drive_word0(8'(k));
    ready0 = 1'b1;
    s0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ready0 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ovf0 !== 1'b1 || valid0 !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL restart_pre: got ovf=%b valid=%b, want 1 1", ovf0, valid0);
    end
    start0 = 1'b1;
    ready0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    ready0 = 1'b0;
    n_checks++;
    if (valid0 !== 1'b0 || ovf0 !== 1'b0 || busy0 !== 1'b1 || core_rst0 !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL restart_flush: got valid=%b ovf=%b busy=%b core_rst=%b, want 0 0 1 1",
               valid0, ovf0, busy0, core_rst0);
    end
    @(negedge clk);
    b = 8'h81;
    for (int i = 0; i < 7; i++) begin
      s0 = b[i];
      @(negedge clk);
    end
    n_checks++;
    if (valid0 !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL restart_early: got valid=%b, want 0", valid0);
    end
    s0 = b[7];
    @(negedge clk);
    n_checks++;
    if (valid0 !== 1'b1 || word0 !== pack8(8'h81)) begin
      n_fails++;
      $display("[TB] FAIL restart_word: got valid=%b word=%h, want 1 %h", valid0, word0, pack8(8'h81));
    end
  endtask

  task automatic test_async_reset();
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (busy16 !== 1'b1 || core_rst16 !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL arst_pre: got busy=%b core_rst=%b, want 1 0", busy16, core_rst16);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({core_rst16, busy16, valid16, ovf16, word16} !== {4'b1000, 8'h00}) begin
      n_fails++;
      $display("[TB] FAIL arst_now: got core_rst/busy/valid/ovf/word=%b%b%b%b/%h, want 1000/00",
               core_rst16, busy16, valid16, ovf16, word16);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_core_integration();
    logic [288:1] x;
    logic [31:0]  bits;
    logic         found;
    x = TINIT;
    for (int i = 0; i < 32; i++) begin
      bits[i] = triv_z(x);
      x = triv_step(x);
    end
    readyt = 1'b1;
    startt = 1'b1;
    @(negedge clk);
    startt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      found = 1'b0;
      for (int c = 0; c < 24 && !found; c++) begin
        @(negedge clk);
        if (validt) found = 1'b1;
      end
      n_checks++;
      if (!found) begin
        n_fails++;
        $display("[TB] FAIL core_word%0d: got no valid word within 24 cycles, want %h", k, pack8(bits[8*k +: 8]));
      end else if (wordt !== pack8(bits[8*k +: 8])) begin
        n_fails++;
        $display("[TB] FAIL core_word%0d: got %h, want %h", k, wordt, pack8(bits[8*k +: 8]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_pack();
    test_warmup();
    test_overflow();
    test_full_push_pop();
    test_restart();
    test_async_reset();
    test_core_integration();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
